// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: sequencer states, default widths
// and the operation codes the downstream ALU decodes.
package operand_loader_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_OPW   = 3;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } state_e;

  // Operation codes as seen on Op by the ALU operation units
  localparam logic [DEF_OPW-1:0] OP_AND = 3'd0;
  localparam logic [DEF_OPW-1:0] OP_OR  = 3'd1;
  localparam logic [DEF_OPW-1:0] OP_XOR = 3'd2;
  localparam logic [DEF_OPW-1:0] OP_ADD = 3'd3;
  localparam logic [DEF_OPW-1:0] OP_SUB = 3'd4;
  localparam logic [DEF_OPW-1:0] OP_NOT = 3'd5;

endpackage

// File: rtl/operand_loader_if.sv
// Board-side bundle of the operand loader: switches/buttons in, captured
// operands and status out.
interface operand_loader_if
  import operand_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
);
  logic [WIDTH-1:0] D;
  logic             Load;
  logic             Clear;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OPW-1:0]   Op;
  logic             Ready;
  logic             Start;
  logic [1:0]       Step;

  modport master (output D, Load, Clear, input A, B, Op, Ready, Start, Step);
  modport slave  (input D, Load, Clear, output A, B, Op, Ready, Start, Step);
endinterface

// File: rtl/operand_loader_edge_detect.sv
// Rising-edge detector: one cycle of history, pulse while din is high and the
// previous sampled value was low.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic din_q;
  logic din_d;

  always_comb din_d = din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din_d;
  end

  assign pulse = din & ~din_q;
endmodule

// File: rtl/operand_loader.sv
// Sequential ALU front end: captures A, B and Op from one data bus on
// successive Load presses and presents them as a stable, valid set.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
) (
  input  logic            clk,
  input  logic            rst,
  operand_loader_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             start_q, start_d;
  logic             load_evt;

  // The edge register samples Load regardless of Clear, so a held button
  // cannot fire again once Clear is released.
  edge_detect u_load_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.Load),
    .pulse (load_evt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    start_d = 1'b0;
    if (bus.Clear) begin
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else if (load_evt) begin
      unique case (state_q)
        LOAD_A, READY: begin
          a_d     = bus.D;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = bus.D;
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          op_d    = bus.D[OPW-1:0];
          state_d = READY;
          start_d = 1'b1;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      start_q <= start_d;
    end
  end

  assign bus.A     = a_q;
  assign bus.B     = b_q;
  assign bus.Op    = op_q;
  assign bus.Ready = (state_q == READY);
  assign bus.Start = start_q;
  assign bus.Step  = state_q;
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: capture sequence, held button, reload,
// clear priority, asynchronous reset and the downstream AND result.
module tb_operand_loader;
  import operand_loader_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  operand_loader_if #(.WIDTH(4), .OPW(3)) bus ();

  operand_loader #(.WIDTH(4), .OPW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press and release: capture happens on the first edge
  task automatic press(input logic [3:0] d);
    bus.D    = d;
    bus.Load = 1'b1;
    tick();
    bus.Load = 1'b0;
    tick();
    $display("press D=%h -> A=%h B=%h Op=%0d Step=%0d Ready=%b", d, bus.A, bus.B, bus.Op, bus.Step, bus.Ready);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.D     = 4'h0;
    bus.Load  = 1'b0;
    bus.Clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.A !== 4'h0) begin errors++; $display("FAIL reset_A got %h want 0", bus.A); end
    checks++; if (bus.B !== 4'h0) begin errors++; $display("FAIL reset_B got %h want 0", bus.B); end
    checks++; if (bus.Op !== 3'd0) begin errors++; $display("FAIL reset_Op got %0d want 0", bus.Op); end
    checks++; if ({bus.Ready, bus.Start, bus.Step} !== 4'b0000) begin errors++; $display("FAIL reset_status got R=%b S=%b Step=%0d want 0/0/0", bus.Ready, bus.Start, bus.Step); end
    $display("reset done");
  endtask

  task automatic test_basic_sequence();
    press(4'hA);
    checks++; if (bus.A !== 4'hA || bus.Step !== 2'd1) begin errors++; $display("FAIL seq_A got A=%h Step=%0d want A Step=1", bus.A, bus.Step); end
    press(4'h5);
    checks++; if (bus.B !== 4'h5 || bus.Step !== 2'd2) begin errors++; $display("FAIL seq_B got B=%h Step=%0d want 5 Step=2", bus.B, bus.Step); end
    checks++; if (bus.Ready !== 1'b0) begin errors++; $display("FAIL seq_not_ready got %b want 0", bus.Ready); end
    bus.D    = 4'h1;
    bus.Load = 1'b1;
    tick();
    checks++; if (bus.Op !== 3'd1 || bus.Step !== 2'd3) begin errors++; $display("FAIL seq_Op got Op=%0d Step=%0d want 1 Step=3", bus.Op, bus.Step); end
    checks++; if (bus.Ready !== 1'b1 || bus.Start !== 1'b1) begin errors++; $display("FAIL seq_start got R=%b S=%b want 1/1", bus.Ready, bus.Start); end
    bus.Load = 1'b0;
    tick();
    checks++; if (bus.Ready !== 1'b1 || bus.Start !== 1'b0) begin errors++; $display("FAIL seq_start_pulse got R=%b S=%b want 1/0", bus.Ready, bus.Start); end
    checks++; if (bus.A !== 4'hA || bus.B !== 4'h5) begin errors++; $display("FAIL seq_stable got A=%h B=%h want A/5", bus.A, bus.B); end
    $display("sequence A=%h B=%h Op=%0d Ready=%b", bus.A, bus.B, bus.Op, bus.Ready);
  endtask

  task automatic test_reload_in_ready();
    bus.D    = 4'hF;
    bus.Load = 1'b1;
    tick();
    checks++; if (bus.A !== 4'hF || bus.Ready !== 1'b0 || bus.Step !== 2'd1) begin errors++; $display("FAIL reload got A=%h R=%b Step=%0d want F/0/1", bus.A, bus.Ready, bus.Step); end
    checks++; if (bus.B !== 4'h5 || bus.Op !== 3'd1 || bus.Start !== 1'b0) begin errors++; $display("FAIL reload_keep got B=%h Op=%0d S=%b want 5/1/0", bus.B, bus.Op, bus.Start); end
    bus.Load = 1'b0;
    tick();
    $display("reload A=%h B=%h Op=%0d Step=%0d", bus.A, bus.B, bus.Op, bus.Step);
  endtask

  task automatic test_hold_load();
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    checks++; if (bus.Step !== 2'd0 || bus.A !== 4'h0 || bus.B !== 4'h0) begin errors++; $display("FAIL clear_state got Step=%0d A=%h B=%h want 0/0/0", bus.Step, bus.A, bus.B); end
    bus.D    = 4'h3;
    bus.Load = 1'b1;
    tick();
    // A second event would write this value into B
    bus.D = 4'h6;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (bus.A !== 4'h3 || bus.Step !== 2'd1) begin errors++; $display("FAIL hold_capture got A=%h Step=%0d want 3/1", bus.A, bus.Step); end
    checks++; if (bus.B !== 4'h0) begin errors++; $display("FAIL hold_no_recapture got B=%h want 0", bus.B); end
    bus.Load = 1'b0;
    tick();
    $display("hold A=%h B=%h Step=%0d", bus.A, bus.B, bus.Step);
  endtask

  task automatic test_clear_priority();
    press(4'h2);
    checks++; if (bus.Step !== 2'd2 || bus.B !== 4'h2) begin errors++; $display("FAIL clrp_setup got Step=%0d B=%h want 2/2", bus.Step, bus.B); end
    bus.D     = 4'h7;
    bus.Load  = 1'b1;
    bus.Clear = 1'b1;
    tick();
    checks++; if (bus.Step !== 2'd0 || bus.A !== 4'h0 || bus.B !== 4'h0 || bus.Op !== 3'd0) begin errors++; $display("FAIL clrp_state got Step=%0d A=%h B=%h Op=%0d want 0/0/0/0", bus.Step, bus.A, bus.B, bus.Op); end
    checks++; if (bus.Ready !== 1'b0 || bus.Start !== 1'b0) begin errors++; $display("FAIL clrp_status got R=%b S=%b want 0/0", bus.Ready, bus.Start); end
    bus.Clear = 1'b0;
    tick();
    checks++; if (bus.Step !== 2'd0 || bus.A !== 4'h0) begin errors++; $display("FAIL clrp_held_button got Step=%0d A=%h want 0/0", bus.Step, bus.A); end
    bus.Load = 1'b0;
    tick();
    $display("clear priority Step=%0d A=%h", bus.Step, bus.A);
  endtask

  task automatic test_async_reset();
    press(4'h9);
    checks++; if (bus.Step !== 2'd1 || bus.A !== 4'h9) begin errors++; $display("FAIL arst_setup got Step=%0d A=%h want 1/9", bus.Step, bus.A); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.A !== 4'h0 || bus.Step !== 2'd0 || bus.Ready !== 1'b0) begin errors++; $display("FAIL arst_immediate got A=%h Step=%0d R=%b want 0/0/0", bus.A, bus.Step, bus.Ready); end
    bus.D    = 4'h4;
    bus.Load = 1'b1;
    #1 rst = 1'b0;
    tick();
    checks++; if (bus.A !== 4'h4 || bus.Step !== 2'd1) begin errors++; $display("FAIL arst_release_event got A=%h Step=%0d want 4/1", bus.A, bus.Step); end
    bus.Load = 1'b0;
    tick();
    $display("async reset A=%h Step=%0d", bus.A, bus.Step);
  endtask

  task automatic test_and_downstream();
    logic [3:0] and_res;
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    press(4'hC);
    press(4'hA);
    press({1'b0, OP_AND});
    and_res = bus.A & bus.B;
    checks++; if (bus.Ready !== 1'b1 || bus.Op !== OP_AND) begin errors++; $display("FAIL and_ready got R=%b Op=%0d want 1/%0d", bus.Ready, bus.Op, OP_AND); end
    checks++; if (and_res !== 4'h8) begin errors++; $display("FAIL and_result got %h want 8", and_res); end
    $display("and A=%h B=%h result=%h", bus.A, bus.B, and_res);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_sequence();
    test_reload_in_ready();
    test_hold_load();
    test_clear_priority();
    test_async_reset();
    test_and_downstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
# operand_loader

Sequential front end of the ALU datapath. Captures operand A, operand B and a 3-bit operation code, one after another, from a single 4-bit data input on successive `Load` button presses. It then presents them, stable and flagged valid, to the combinational ALU stage: the bitwise units such as the 4-bit AND, plus the other operation units. It sits directly upstream of the ALU, between the board switches/buttons and the operation units.

## Interface
Parameters:
- `WIDTH`, 4, operand width in bits (operand width of downstream bitwise units)
- `OPW`, 3, operation-code width; must satisfy OPW ≤ WIDTH

Ports:
- `clk`  input  1  single system clock, rising-edge active
- `rst`  input  1  asynchronous, active-high reset
- `D`  input  WIDTH  data switches; operand or op code to capture
- `Load`  input  1  level from load button, already debounced; raw level, edge-detected internally
- `Clear`  input  1  synchronous clear, level-sensitive
- `A`  output  WIDTH  captured operand A
- `B`  output  WIDTH  captured operand B
- `Op`  output  OPW  captured operation code (`D[OPW-1:0]`)
- `Ready`  output  1  high while A, B and Op form a complete valid set
- `Start`  output  1  one-cycle pulse on the cycle Ready first rises
- `Step`  output  2  current state encoding, for display LEDs

## Operation
- Load event: a rising edge on `Load`, i.e. `Load`=1 while the registered previous value was 0. Holding `Load` high yields exactly one event.
- States: LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3. `Step` equals the state.
- LOAD_A + event: `A<=D`, go to LOAD_B.
- LOAD_B + event: `B<=D`, go to LOAD_OP.
- LOAD_OP + event: `Op<=D[OPW-1:0]`, go to READY.
- READY + event: `A<=D`, go to LOAD_B.
  - `Ready` drops.
  - B and Op keep their old values until overwritten but are not valid.
- No event: state and all registers hold.
- `Clear`=1: next edge forces LOAD_A and zeroes A, B and Op.
  - `Clear` has priority over a coincident load event; that event is discarded.
  - The edge-detect register still samples `Load`, so a button held through `Clear` produces no event after release of `Clear`.
- `Ready` = (state == READY), decoded from registered state, glitch-free.
- `Start` is registered. It is 1 exactly in the first cycle of READY, i.e. the cycle after the LOAD_OP event edge, and 0 otherwise.
- Reset (any time, including mid-sequence): state LOAD_A, A=B=Op=0, `Ready`=0, `Start`=0, `Step`=0, edge register=0.
  - Consequence: if `Load` is high when reset releases, one event fires on the first clock.

## Timing
- Latency: a load event sampled at edge N updates the target register and state at edge N. The new value is visible on outputs after edge N, with no extra pipeline stage.
- Edge detection adds one cycle of history only. An event needs `Load` low for at least one sampled cycle before high.
- Outputs are purely registered or decoded from registers. The downstream ALU sees stable operands for the entire READY interval.
- Minimum full sequence: three events. `Ready` and `Start` assert after the third event edge.
- Back-to-back events are impossible by construction; at least 2 cycles separate events.

## Structure
- Shared package holds:
  - state constants LOAD_A, LOAD_B, LOAD_OP and READY (2-bit)
  - default WIDTH/OPW values
  - op-code constants consumed by the ALU (e.g. AND)
- One natural sub-module: `edge_detect` (register plus rising-edge pulse, async active-high reset). Instantiated once for `Load`.
- The rest is one state register, three capture registers and the `Start` register in the top module. Expected size is about 150 lines.

## Test plan
- Reset then three clean presses with D=0xA, 0x5, 0x1 -> A=0xA, B=0x5, Op=1, `Ready`=1, `Start` high for exactly one cycle, `Step`=3.
- Hold `Load` high for 10 cycles in LOAD_A with D=0x3 -> A=0x3, single transition to LOAD_B, no further captures.
- In READY, press with D=0xF -> A=0xF, `Ready`=0, `Step`=1, and B/Op unchanged (0x5/1).
- In LOAD_OP, assert `Clear` on the same cycle as a load edge -> state LOAD_A, A=B=Op=0, no capture.
- Assert `rst` asynchronously mid-clock while in LOAD_B -> all outputs 0 immediately, without waiting for a clock edge. `Load` high at release -> A captures D on the first clock.
- Drive outputs into the 4-bit AND: A=0xC, B=0xA -> downstream result 0x8 while `Ready`=1.
